// File: rtl/hist_bin_reader_pkg.sv
// Purpose: shared jet-finding constants and the scan FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_bin_reader_pkg;

    localparam int NBINS  = 32;
    localparam int ETA_W  = 5;
    localparam int PT_W   = 9;
    localparam int NTRX_W = 5;
    localparam int NX_W   = 4;
    localparam int SUM_W  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hist_peak_track.sv
// Purpose: 3-bin sliding-window pT sum over the bin stream, keeps the best window.
// Latency: window for centre c is judged when bin c+1 arrives (last centre one cycle after the last bin); result registered.
// Backpressure: none; consumes one bin per cycle whenever i_vld is high.
//
// Ports: i_clk/i_reset clock and sync reset; i_clear re-arms the tracker at scan start;
//        i_vld/i_eta/i_pt bin stream; o_peak_eta/o_peak_sum best window so far.
module hist_peak_track
    import hist_bin_reader_pkg::*;
#(
    parameter int NBINS = hist_bin_reader_pkg::NBINS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_vld,
    input  logic [ETA_W-1:0] i_eta,
    input  logic [PT_W-1:0]  i_pt,
    output logic [ETA_W-1:0] o_peak_eta,
    output logic [SUM_W-1:0] o_peak_sum
);

    localparam logic [ETA_W-1:0] LAST_ETA = ETA_W'(NBINS - 1);

    logic [PT_W-1:0]  r_pt_c;     // pt of the most recent bin (window centre)
    logic [PT_W-1:0]  r_pt_l;     // pt of the bin before it (left neighbour)
    logic             r_flush;    // cycle after the last bin: judge the final centre
    logic [SUM_W-1:0] r_best_sum;
    logic [ETA_W-1:0] r_best_eta;

    logic             w_eval;
    logic [PT_W-1:0]  w_right;
    logic [SUM_W-1:0] w_sum;
    logic [ETA_W-1:0] w_centre;

    // Bin 0 has no left neighbour to complete, so it only primes the window.
    assign w_eval   = (i_vld && (i_eta != '0)) || r_flush;
    // In the flush cycle the right neighbour lies beyond the last bin and counts as 0.
    assign w_right  = i_vld ? i_pt : '0;
    assign w_sum    = SUM_W'(r_pt_l) + SUM_W'(r_pt_c) + SUM_W'(w_right);
    assign w_centre = r_flush ? LAST_ETA : ETA_W'(i_eta - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_pt_c     <= '0;
            r_pt_l     <= '0;
            r_flush    <= 1'b0;
            r_best_sum <= '0;
            r_best_eta <= '0;
        end else begin
            if (i_vld) begin
                r_pt_l <= r_pt_c;
                r_pt_c <= i_pt;
            end
            r_flush <= i_vld && (i_eta == LAST_ETA);
            // Strictly greater only: on a tie the earlier (lower eta) centre is kept.
            if (w_eval && (w_sum > r_best_sum)) begin
                r_best_sum <= w_sum;
                r_best_eta <= w_centre;
            end
        end
    end

    assign o_peak_eta = r_best_eta;
    assign o_peak_sum = r_best_sum;

endmodule

// File: rtl/hist_bin_reader.sv
// Purpose: scans all eta bins of the histogram after each event, streams bin records and reports the best 3-bin window.
// Latency: readeta=k one cycle after start+k; bin k presented READ_LAT cycles after its readeta; peak READ_LAT+2 cycles after the last readeta.
// Backpressure: none; start is ignored while busy, the histogram must return data on the fixed READ_LAT schedule.
//
// Ports: i_clk, i_reset (sync, active high), i_start (end-of-event pulse);
//        i_e_tot/i_ntrx/i_xcount returned bin contents; o_clustering/o_readeta drive the histogram;
//        o_busy scan in progress; o_bin_* one bin record per cycle; o_peak_* best window, one-cycle pulse.
module hist_bin_reader
    import hist_bin_reader_pkg::*;
#(
    parameter int NBINS    = hist_bin_reader_pkg::NBINS,
    parameter int READ_LAT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PT_W-1:0]   i_e_tot,
    input  logic [NTRX_W-1:0] i_ntrx,
    input  logic [NX_W-1:0]   i_xcount,
    output logic              o_clustering,
    output logic [ETA_W-1:0]  o_readeta,
    output logic              o_busy,
    output logic              o_bin_valid,
    output logic [ETA_W-1:0]  o_bin_eta,
    output logic [PT_W-1:0]   o_bin_pt,
    output logic [NTRX_W-1:0] o_bin_ntrx,
    output logic [NX_W-1:0]   o_bin_nx,
    output logic              o_peak_valid,
    output logic [ETA_W-1:0]  o_peak_eta,
    output logic [SUM_W-1:0]  o_peak_sum
);

    localparam logic [ETA_W-1:0] LAST_ADDR = ETA_W'(NBINS - 1);

    state_t                          r_state;
    state_t                          w_next;
    logic [ETA_W-1:0]                r_addr;
    logic [READ_LAT-1:0]             r_vld;   // issued-read flags travelling with the memory latency
    logic [READ_LAT-1:0][ETA_W-1:0]  r_eta;   // matching bin addresses

    logic             w_issue;
    logic             w_start_scan;
    logic             w_bin_vld;
    logic [ETA_W-1:0] w_peak_eta;
    logic [SUM_W-1:0] w_peak_sum;

    assign w_issue = (r_state == SCAN);

    always_comb begin
        w_next       = r_state;
        w_start_scan = 1'b0;
        o_clustering = 1'b0;
        o_busy       = 1'b1;
        o_peak_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next       = SCAN;
                    w_start_scan = 1'b1;
                end
            end
            SCAN: begin
                o_clustering = 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                // Empty pipe means the last bin was presented last cycle and the
                // tracker is judging the final centre now.
                o_clustering = 1'b1;
                if (r_vld == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_peak_valid = 1'b1;
                w_next       = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_vld   <= '0;
            r_eta   <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
            r_vld[0] <= w_issue;
            r_eta[0] <= r_addr;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_eta[i] <= r_eta[i-1];
            end
        end
    end

    // Returned data is only meaningful in the capture cycle; elsewhere it is masked.
    assign w_bin_vld   = r_vld[READ_LAT-1];
    assign o_bin_valid = w_bin_vld;
    assign o_bin_eta   = w_bin_vld ? r_eta[READ_LAT-1] : '0;
    assign o_bin_pt    = w_bin_vld ? i_e_tot  : '0;
    assign o_bin_ntrx  = w_bin_vld ? i_ntrx   : '0;
    assign o_bin_nx    = w_bin_vld ? i_xcount : '0;
    assign o_readeta   = r_addr;

    hist_peak_track #(
        .NBINS (NBINS)
    ) u_peak (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_start_scan),
        .i_vld      (w_bin_vld),
        .i_eta      (o_bin_eta),
        .i_pt       (o_bin_pt),
        .o_peak_eta (w_peak_eta),
        .o_peak_sum (w_peak_sum)
    );

    assign o_peak_eta = o_peak_valid ? w_peak_eta : '0;
    assign o_peak_sum = o_peak_valid ? w_peak_sum : '0;

endmodule

// File: doc/hist_bin_reader.md
HIST_BIN_READER -- requirements
Module: hist_bin_reader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NBINS, default 32, SHALL set the number of eta bins scanned.
REQ-003 Parameter READ_LAT, default 3, SHALL set the cycles from readeta issue to the returned bin data.
REQ-004 clk  in  1  sole clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  end-of-event pulse; begins a histogram scan.
REQ-007 E_tot  in  9  bin pT total returned by the histogram.
REQ-008 ntrx  in  5  bin track count returned.
REQ-009 xcount  in  4  bin special-track count returned.
REQ-010 clustering  out  1  tells the histogram writer to serve reads and zero each bin after it is read.
REQ-011 readeta  out  5  bin address being read.
REQ-012 busy  out  1  scan in progress.
REQ-013 bin_valid  out  1  qualifies bin_eta, bin_pt, bin_ntrx and bin_nx.
REQ-014 bin_eta / bin_pt / bin_ntrx / bin_nx  out  5/9/5/4  one bin record.
REQ-015 peak_valid  out  1  one-cycle pulse qualifying peak_eta and peak_sum.
REQ-016 peak_eta / peak_sum  out  5/11  centre bin and pT sum of the best 3-bin window.

Function
REQ-017 The state machine SHALL have four states: IDLE, SCAN, DRAIN and DONE.
REQ-018 In IDLE with start=1 at edge 0, the block SHALL enter SCAN; SCAN SHALL occupy cycles 1..NBINS, with readeta=k in cycle 1+k.
REQ-019 The block SHALL capture inputs in cycle 1+k+READ_LAT and present them as bin_valid=1 with bin_eta=k and the captured values, one bin per cycle, with no gaps.
REQ-020 After the last readeta, the block SHALL enter DRAIN until the last bin_valid, plus 1 cycle.
REQ-021 It SHALL then enter DONE for 1 cycle with peak_valid=1, then return to IDLE.
REQ-022 clustering SHALL be 1 from cycle 1 through the cycle after the last bin_valid, and 0 in DONE and IDLE.
REQ-023 busy SHALL be 1 in SCAN, DRAIN and DONE.
REQ-024 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-025 The window sum for centre c SHALL be pt[c-1]+pt[c]+pt[c+1]; out-of-range neighbours SHALL count as 0; the sum SHALL be 11-bit and unsaturated (max 1533).
REQ-026 The window for centre c SHALL be evaluated once pt[c+1] arrives; centre NBINS-1 SHALL be evaluated in the cycle after the last bin, using 0 for the missing neighbour.
REQ-027 The peak SHALL update only on a strictly greater sum, so ties resolve to the lowest eta; the tracker SHALL initialise to sum 0 and eta 0 at each scan start.
REQ-028 The block SHALL ignore E_tot/ntrx/xcount outside capture cycles.

Reset
REQ-029 On reset=1, the block SHALL enter IDLE; all outputs SHALL be 0; the delay pipeline and peak tracker SHALL be cleared.
REQ-030 Reset mid-scan SHALL abort the scan with no further bin_valid or peak_valid, and clustering SHALL be 0 in the next cycle.
REQ-031 A scan aborted by reset SHALL leave bins unread and unzeroed; clearing them is the system's responsibility.

Structure
REQ-032 The shared jet-finding package SHALL hold constants NBINS, ETA_W=5, PT_W=9, NTRX_W=5, NX_W=4, SUM_W=11 and the state enum type.
REQ-033 The 3-bin window sum and max tracking SHALL be one sub-module, hist_peak_track, fed by the bin stream.
REQ-034 The top level SHALL hold the FSM, the address counter and the READ_LAT valid/eta delay line.

Verification
REQ-035 All bins zero, start at cycle 0 -> readeta 0..31 in cycles 1..32; bin_valid in cycles 4..35 with pt=0; peak_valid in cycle 37 with peak_sum=0 and peak_eta=0.
REQ-036 Only bin 10 has pt=100, ntrx=3, xcount=1 -> bin record eta 10 = {100,3,1}; peak_sum=100, peak_eta=9 (three-way tie; lowest eta wins).
REQ-037 Bin 0 pt=511, bin 1 pt=511 -> peak_sum=1022, peak_eta=0; bin 31 pt=300 alone -> peak_eta=30, peak_sum=300.
REQ-038 Bins 5,6,7 pt=200,300,200 and bin 20 pt=511 -> peak_eta=6, peak_sum=700.
REQ-039 start re-pulsed at cycle 10 -> ignored; exactly 32 bin_valid and one peak_valid; next start in IDLE accepted.
REQ-040 reset at cycle 15 -> clustering=0, busy=0 and bin_valid=0 from cycle 16; no peak_valid; a fresh start then yields a full scan.
